// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the pixel-path sequencing blocks:
// frame-sequencer state encoding and a constant-width helper.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits needed to count 0..value-1; never narrower than one bit.
  function automatic int CLOG2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/shift_ctrl_vld_delay.sv
// Fixed-latency pipe that lines the window metadata up with the
// line-buffer taps. Cleared asynchronously so a reset empties it at once.
module vld_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] r_pipe;

      // Shift the metadata one stage per clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/shift_ctrl.sv
// Frame sequencer for the 5-tap line buffer: forwards the pixel stream,
// appends PAD zero rows, and produces window-centre metadata aligned to
// the line-buffer taps.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int ROW    = 480,
  parameter int COL    = 640,
  parameter int DW     = 8,
  parameter int PAD    = 2,
  parameter int LB_LAT = 1
) (
  input  logic                   vga_clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [DW-1:0]          din,
  input  logic                   din_vld,
  output logic [DW-1:0]          lb_din,
  output logic                   lb_din_vld,
  output logic [CLOG2(COL)-1:0]  ctr_x,
  output logic [CLOG2(ROW)-1:0]  ctr_y,
  output logic                   win_vld,
  output logic                   border,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_drop,
  output logic                   err_abort
);

  localparam int XW  = CLOG2(COL);
  localparam int YW  = CLOG2(ROW);
  localparam int IYW = CLOG2(ROW + PAD);
  localparam int CW  = XW + YW + 2;

  localparam logic [XW-1:0]  X_LAST       = XW'(COL - 1);
  localparam logic [IYW-1:0] Y_PIX_LAST   = IYW'(ROW - 1);
  localparam logic [IYW-1:0] Y_FLUSH_LAST = IYW'(ROW + PAD - 1);
  localparam logic [IYW-1:0] Y_PAD        = IYW'(PAD);

  state_e           r_state, w_state_next;
  logic [XW-1:0]    r_in_x, w_in_x_next, w_cur_x, w_ctr_x;
  logic [IYW-1:0]   r_in_y, w_in_y_next, w_cur_y;
  logic [YW-1:0]    w_ctr_y;
  logic             w_accept, w_flush_shift, w_shift;
  logic             w_last_pix, w_last_flush;
  logic             w_ctr_vld, w_border;
  logic [DW-1:0]    r_lb_din, w_lb_din_next;
  logic             r_lb_vld;
  logic             r_frame_done, w_frame_done_next;
  logic             r_err_drop, w_err_drop_next;
  logic             r_err_abort, w_err_abort_next;
  logic [CW-1:0]    r_ctr_stage, w_ctr_stage_next, w_ctr_delayed;

  // Shift decision, position counters and centre mapping for this cycle.
  // A frame_start makes the current position (0,0) so a pixel arriving
  // with it is the first pixel of the new frame.
  always_comb begin
    w_cur_x       = frame_start ? '0 : r_in_x;
    w_cur_y       = frame_start ? '0 : r_in_y;
    w_accept      = din_vld && (frame_start || (r_state == ST_RUN));
    w_flush_shift = !frame_start && (r_state == ST_FLUSH);
    w_shift       = w_accept || w_flush_shift;
    w_last_pix    = w_accept && (w_cur_x == X_LAST) && (w_cur_y == Y_PIX_LAST);
    w_last_flush  = w_flush_shift && (w_cur_x == X_LAST) && (w_cur_y == Y_FLUSH_LAST);

    w_in_x_next = r_in_x;
    w_in_y_next = r_in_y;
    if (w_shift) begin
      if (w_cur_x == X_LAST) begin
        w_in_x_next = '0;
        w_in_y_next = w_cur_y + IYW'(1);
      end else begin
        w_in_x_next = w_cur_x + XW'(1);
        w_in_y_next = w_cur_y;
      end
    end else if (frame_start) begin
      w_in_x_next = '0;
      w_in_y_next = '0;
    end

    // Centre row lags the shifted row by PAD; only rows >= PAD map to a centre.
    w_ctr_vld = w_shift && (w_cur_y >= Y_PAD);
    w_ctr_x   = '0;
    w_ctr_y   = '0;
    if (w_ctr_vld) begin
      w_ctr_x = w_cur_x;
      w_ctr_y = YW'(w_cur_y - Y_PAD);
    end
    w_border = w_ctr_vld &&
               ((int'(w_ctr_x) < PAD) || (int'(w_ctr_x) >= COL - PAD) ||
                (int'(w_ctr_y) < PAD) || (int'(w_ctr_y) >= ROW - PAD));

    w_lb_din_next    = w_accept ? din : '0;
    w_ctr_stage_next = {w_ctr_vld, w_border, w_ctr_x, w_ctr_y};
  end

  // Next-state and pulse outputs; a restart or the final pixel override
  // the per-state transition.
  always_comb begin
    w_state_next      = r_state;
    w_frame_done_next = (r_state == ST_DONE) && !frame_start;
    w_err_drop_next   = din_vld && !frame_start &&
                        ((r_state == ST_FLUSH) || (r_state == ST_DONE));
    w_err_abort_next  = frame_start && (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE:  w_state_next = ST_IDLE;
      ST_RUN:   w_state_next = ST_RUN;
      ST_FLUSH: if (w_last_flush) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (frame_start) w_state_next = ST_RUN;
    if (w_last_pix)  w_state_next = (PAD == 0) ? ST_DONE : ST_FLUSH;
  end

  // State register.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Counters, line-buffer drive, status pulses and first metadata stage.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_x       <= '0;
      r_in_y       <= '0;
      r_lb_din     <= '0;
      r_lb_vld     <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_drop   <= 1'b0;
      r_err_abort  <= 1'b0;
      r_ctr_stage  <= '0;
    end else begin
      r_in_x       <= w_in_x_next;
      r_in_y       <= w_in_y_next;
      r_lb_din     <= w_lb_din_next;
      r_lb_vld     <= w_shift;
      r_frame_done <= w_frame_done_next;
      r_err_drop   <= w_err_drop_next;
      r_err_abort  <= w_err_abort_next;
      r_ctr_stage  <= w_ctr_stage_next;
    end
  end

  vld_delay #(
    .W     (CW),
    .DEPTH (LB_LAT)
  ) u_vld_delay (
    .clk   (vga_clk),
    .rst_n (rst_n),
    .i_d   (r_ctr_stage),
    .o_q   (w_ctr_delayed)
  );

  assign {win_vld, border, ctr_x, ctr_y} = w_ctr_delayed;
  assign lb_din     = r_lb_din;
  assign lb_din_vld = r_lb_vld;
  assign frame_done = r_frame_done;
  assign err_drop   = r_err_drop;
  assign err_abort  = r_err_abort;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl with a frame-level reference model.
module tb_shift_ctrl;

  localparam int ROW = 6, COL = 8, DW = 8, PAD = 2, LB_LAT = 1;
  localparam int NPIX = ROW * COL;
  localparam int NTOT = NPIX + PAD * COL;

  logic          vga_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic [DW-1:0] lb_din;
  logic          lb_din_vld;
  logic [2:0]    ctr_x, ctr_y;
  logic          win_vld, border, busy, frame_done, err_drop, err_abort;

  shift_ctrl #(.ROW(ROW), .COL(COL), .DW(DW), .PAD(PAD), .LB_LAT(LB_LAT)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .frame_start(frame_start), .din(din),
    .din_vld(din_vld), .lb_din(lb_din), .lb_din_vld(lb_din_vld), .ctr_x(ctr_x),
    .ctr_y(ctr_y), .win_vld(win_vld), .border(border), .busy(busy),
    .frame_done(frame_done), .err_drop(err_drop), .err_abort(err_abort));

  always #5 vga_clk = ~vga_clk;

  logic [20:0] obs;
  assign obs = {busy, frame_done, err_drop, err_abort, lb_din_vld, lb_din,
                win_vld, border, ctr_x, ctr_y};

  int n_cmp = 0, n_mis = 0, cyc = 0;

  // Reference model: a frame is a linear sequence of NTOT shifts followed by
  // one completion cycle; position = shifts done so far in the frame.
  bit          m_active = 0;
  int          m_pos = 0;
  logic [7:0]  m_hist [LB_LAT];
  logic [20:0] exp_vec = '0;

  // Observation tallies.
  int t_lb, t_seq, t_zero, t_win, t_blow, t_blow_in, t_fdone, t_drop, t_abort;
  int last_lb_cyc, fdone_cyc, first_win_cyc;
  logic [5:0] first_ctr, last_ctr;

  function automatic bit border_of(input int x, input int y);
    return (x < PAD) || (x >= COL - PAD) || (y < PAD) || (y >= ROW - PAD);
  endfunction

  task automatic clear_tally();
    t_lb = 0; t_seq = 0; t_zero = 0; t_win = 0; t_blow = 0; t_blow_in = 0;
    t_fdone = 0; t_drop = 0; t_abort = 0;
    last_lb_cyc = -1; fdone_cyc = -1; first_win_cyc = -1;
    first_ctr = '1; last_ctr = '1;
  endtask

  task automatic model_reset();
    m_active = 0; m_pos = 0; exp_vec = '0;
    for (int i = 0; i < LB_LAT; i++) m_hist[i] = '0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit fs, input bit vld, input logic [7:0] d);
    bit sh, drop, abort, fdone;
    logic [7:0] ld, c_new;
    int x, y;
    logic [31:0] xv, yv;
    frame_start = fs; din_vld = vld; din = d;
    @(posedge vga_clk);
    cyc++;
    sh = 0; drop = 0; abort = 0; fdone = 0; ld = '0; c_new = '0;
    if (fs) begin abort = m_active; m_active = 1; m_pos = 0; end
    if (m_active) begin
      if (m_pos < NPIX) begin
        if (vld) begin sh = 1; ld = d; end
      end else if (m_pos < NTOT) begin
        sh = 1; drop = vld;
      end else begin
        fdone = 1; m_active = 0; drop = vld;
      end
    end
    if (sh) begin
      x = m_pos % COL; y = m_pos / COL;
      if (y >= PAD) begin
        xv = x; yv = y - PAD;
        c_new = {1'b1, border_of(x, y - PAD), xv[2:0], yv[2:0]};
      end
      m_pos++;
    end
    exp_vec = {m_active, fdone, drop, abort, sh, ld, m_hist[LB_LAT-1]};
    for (int i = LB_LAT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = c_new;
    #1;
    if (lb_din_vld) begin
      if (t_lb < NPIX && lb_din == 8'(t_lb)) t_seq++;
      if (t_lb >= NPIX && lb_din == 8'd0) t_zero++;
      t_lb++; last_lb_cyc = cyc;
    end
    if (win_vld) begin
      if (t_win == 0) begin first_win_cyc = cyc; first_ctr = {ctr_x, ctr_y}; end
      last_ctr = {ctr_x, ctr_y};
      t_win++;
      if (!border) begin
        t_blow++;
        if (ctr_x >= 3'd2 && ctr_x <= 3'd5 && ctr_y >= 3'd2 && ctr_y <= 3'd3) t_blow_in++;
      end
    end
    if (frame_done) begin t_fdone++; fdone_cyc = cyc; end
    if (err_drop)  t_drop++;
    if (err_abort) t_abort++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (obs !== 21'd0) begin n_mis++; $display("FAIL reset_async got=%h exp=%h", obs, 21'd0); end
    repeat (2) @(posedge vga_clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (obs !== 21'd0) begin n_mis++; $display("FAIL reset_release got=%h exp=%h", obs, 21'd0); end
    clear_tally();
    for (int i = 0; i < 6; i++) begin
      step(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL idle_ignore cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    $display("[tb] reset: idle cycles checked, lb=%0d", t_lb);
  endtask

  task automatic test_full_frame();
    int p16;
    p16 = -1;
    clear_tally();
    step(1, 0, 8'd0);
    n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL full_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    for (int i = 0; i < NPIX; i++) begin
      step(0, 1, 8'(i));
      if (i == 2 * COL) p16 = cyc;
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL full_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    for (int i = 0; i < 40 && m_active; i++) begin
      step(0, 0, 8'd0);
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL full_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    step(0, 0, 8'd0);
    n_cmp++; if (t_seq != NPIX) begin n_mis++; $display("FAIL full_seq got=%0d exp=%0d", t_seq, NPIX); end
    n_cmp++; if (t_lb != NTOT) begin n_mis++; $display("FAIL full_lb_count got=%0d exp=%0d", t_lb, NTOT); end
    n_cmp++; if (t_zero != PAD * COL) begin n_mis++; $display("FAIL full_flush_zero got=%0d exp=%0d", t_zero, PAD * COL); end
    n_cmp++; if (t_fdone != 1) begin n_mis++; $display("FAIL full_fdone_count got=%0d exp=1", t_fdone); end
    n_cmp++; if (fdone_cyc != last_lb_cyc + 1) begin n_mis++; $display("FAIL full_fdone_time got=%0d exp=%0d", fdone_cyc, last_lb_cyc + 1); end
    n_cmp++; if (t_win != NPIX) begin n_mis++; $display("FAIL full_win_count got=%0d exp=%0d", t_win, NPIX); end
    n_cmp++; if (first_win_cyc != p16 + LB_LAT) begin n_mis++; $display("FAIL full_first_win_time got=%0d exp=%0d", first_win_cyc, p16 + LB_LAT); end
    n_cmp++; if (first_ctr !== 6'o00) begin n_mis++; $display("FAIL full_first_ctr got=%o exp=00", first_ctr); end
    n_cmp++; if (last_ctr !== 6'o75) begin n_mis++; $display("FAIL full_last_ctr got=%o exp=75", last_ctr); end
    n_cmp++; if (t_blow != 8 || t_blow_in != 8) begin n_mis++; $display("FAIL full_border_low got=%0d/%0d exp=8/8", t_blow, t_blow_in); end
    $display("[tb] full_frame: lb=%0d win=%0d frame_done=%0d", t_lb, t_win, t_fdone);
  endtask

  task automatic test_toggle();
    int sent;
    bit v;
    sent = 0;
    clear_tally();
    step(1, 0, 8'd0);
    for (int i = 0; i < 400 && sent < NPIX; i++) begin
      v = (i % 2 == 0);
      step(0, v, 8'($urandom_range(0, 255)));
      if (v) sent++;
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL toggle_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    for (int i = 0; i < 40 && m_active; i++) begin
      step(0, 0, 8'd0);
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL toggle_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    step(0, 0, 8'd0);
    n_cmp++; if (t_lb != NTOT || t_win != NPIX || t_fdone != 1) begin n_mis++; $display("FAIL toggle_counts got=%0d/%0d/%0d exp=%0d/%0d/1", t_lb, t_win, t_fdone, NTOT, NPIX); end
    $display("[tb] toggle: lb=%0d win=%0d frame_done=%0d", t_lb, t_win, t_fdone);
  endtask

  task automatic test_flush_drop();
    clear_tally();
    step(1, 0, 8'd0);
    for (int i = 0; i < NPIX; i++) begin
      step(0, 1, 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL drop_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    // Pixels keep arriving through all flush cycles and the completion cycle.
    for (int i = 0; i < PAD * COL + 1; i++) begin
      step(0, 1, 8'($urandom_range(1, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL drop_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL drop_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    n_cmp++; if (t_drop != PAD * COL + 1) begin n_mis++; $display("FAIL drop_count got=%0d exp=%0d", t_drop, PAD * COL + 1); end
    n_cmp++; if (t_zero != PAD * COL || t_lb != NTOT) begin n_mis++; $display("FAIL drop_flush got=%0d/%0d exp=%0d/%0d", t_zero, t_lb, PAD * COL, NTOT); end
    n_cmp++; if (t_fdone != 1) begin n_mis++; $display("FAIL drop_fdone got=%0d exp=1", t_fdone); end
    $display("[tb] flush_drop: drops=%0d flush=%0d frame_done=%0d", t_drop, t_zero, t_fdone);
  endtask

  task automatic test_abort();
    clear_tally();
    step(1, 0, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL abort_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    step(1, 1, 8'($urandom_range(0, 255)));
    n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    for (int i = 1; i < NPIX; i++) begin
      step(0, 1, 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL abort_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    for (int i = 0; i < 40 && m_active; i++) begin
      step(0, 0, 8'd0);
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL abort_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    step(0, 0, 8'd0);
    n_cmp++; if (t_abort != 1) begin n_mis++; $display("FAIL abort_pulse got=%0d exp=1", t_abort); end
    n_cmp++; if (t_fdone != 1) begin n_mis++; $display("FAIL abort_fdone got=%0d exp=1", t_fdone); end
    n_cmp++; if (t_win != 4 + NPIX) begin n_mis++; $display("FAIL abort_win got=%0d exp=%0d", t_win, 4 + NPIX); end
    $display("[tb] abort: aborts=%0d win=%0d frame_done=%0d", t_abort, t_win, t_fdone);
  endtask

  task automatic test_back_to_back();
    clear_tally();
    step(1, 0, 8'd0);
    for (int i = 0; i < NPIX + PAD * COL; i++) begin
      step(0, (i < NPIX), 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL b2b_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    // Restart lands on the completion cycle of the first frame.
    step(1, 0, 8'd0);
    n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL b2b_restart cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    for (int i = 0; i < NPIX; i++) begin
      step(0, 1, 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL b2b_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    for (int i = 0; i < 40 && m_active; i++) begin
      step(0, 0, 8'd0);
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL b2b_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    step(0, 0, 8'd0);
    n_cmp++; if (t_abort != 1 || t_fdone != 1) begin n_mis++; $display("FAIL b2b_pulses got=%0d/%0d exp=1/1", t_abort, t_fdone); end
    n_cmp++; if (t_lb != 2 * NTOT - PAD * 0 || t_win != 2 * NPIX) begin n_mis++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", t_lb, t_win, 2 * NTOT, 2 * NPIX); end
    $display("[tb] back_to_back: aborts=%0d lb=%0d frame_done=%0d", t_abort, t_lb, t_fdone);
  endtask

  task automatic test_reset_mid_flush();
    clear_tally();
    step(1, 0, 8'd0);
    for (int i = 0; i < NPIX + 5; i++) begin
      step(0, (i < NPIX), 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL rstf_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    frame_start = 1'b0; din_vld = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (obs !== 21'd0) begin n_mis++; $display("FAIL rstf_async got=%h exp=%h", obs, 21'd0); end
    @(posedge vga_clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (obs !== 21'd0) begin n_mis++; $display("FAIL rstf_release got=%h exp=%h", obs, 21'd0); end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'($urandom_range(0, 255)));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL rstf_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    // New frame whose first pixel arrives together with frame_start.
    clear_tally();
    step(1, 1, 8'd0);
    n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL rstf_first cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    for (int i = 1; i < NPIX; i++) begin
      step(0, 1, 8'(i));
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL rstf_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    for (int i = 0; i < 40 && m_active; i++) begin
      step(0, 0, 8'd0);
      n_cmp++; if (obs !== exp_vec) begin n_mis++; $display("FAIL rstf_cyc cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    step(0, 0, 8'd0);
    n_cmp++; if (t_seq != NPIX || t_fdone != 1 || t_abort != 0) begin n_mis++; $display("FAIL rstf_frame got=%0d/%0d/%0d exp=%0d/1/0", t_seq, t_fdone, t_abort, NPIX); end
    $display("[tb] reset_mid_flush: seq=%0d frame_done=%0d", t_seq, t_fdone);
  endtask

  initial begin
    model_reset();
    clear_tally();
    test_reset();
    test_full_frame();
    test_toggle();
    test_flush_drop();
    test_abort();
    test_back_to_back();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Frame sequencer for the 5-tap line buffer (`shift_custom`) in the VGA-clock pixel path. It accepts the raw pixel stream and frame-start pulse, counts row and column, and forwards pixels to the line buffer. After the last real row it pushes PAD rows of zero padding so every image row appears once at the window centre. It also generates centre coordinates, a border flag and a window-valid strobe aligned to the line-buffer taps.

## Interface
- ROW, 480, image rows
- COL, 640, image columns
- DW, 8, pixel width
- PAD, 2, half window height (window = 2*PAD+1 rows)
- LB_LAT, 1, line-buffer cycles from `lb_din_vld` to valid taps
- vga_clk  in  1  pixel clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at frame start (before the first pixel)
- din  in  DW  incoming pixel
- din_vld  in  1  pixel qualifier
- lb_din  out  DW  pixel to line buffer
- lb_din_vld  out  1  line-buffer shift enable
- ctr_x  out  clog2(COL)  window-centre column, aligned to taps
- ctr_y  out  clog2(ROW)  window-centre row, aligned to taps
- win_vld  out  1  taps hold a valid window centred at (ctr_x, ctr_y)
- border  out  1  centre within PAD of any image edge (qualified by win_vld)
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle pulse after the last padded row
- err_drop  out  1  one-cycle pulse when a din_vld pixel is discarded
- err_abort  out  1  one-cycle pulse when frame_start restarts an unfinished frame

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: ignores and does not forward din_vld. On frame_start, clears counters and moves to RUN.
- RUN: each din_vld is forwarded as lb_din = din, lb_din_vld = 1.
  - Input column in_x increments modulo COL; in_y increments on column wrap.
  - Accepting pixel (ROW-1, COL-1) moves the block to FLUSH.
- FLUSH: drives lb_din = 0 and lb_din_vld = 1 every cycle for PAD*COL cycles. in_x/in_y keep counting (in_y runs ROW..ROW+PAD-1). Then moves to DONE.
- DONE: pulses frame_done for one cycle, then moves to IDLE.
- Centre mapping: each shifted pixel at (in_x, in_y) has centre (in_x, in_y-PAD). The centre is valid when in_y ≥ PAD, which gives exactly ROW*COL valid centres per frame.
- border = ctr_x<PAD | ctr_x≥COL-PAD | ctr_y<PAD | ctr_y≥ROW-PAD. Downstream uses it to mask stale or padded taps.
- din_vld in FLUSH or DONE: the pixel is dropped and err_drop pulses.
- frame_start in RUN, FLUSH or DONE: the frame is abandoned, counters clear, state goes to RUN and err_abort pulses. frame_done is not emitted for the aborted frame.
- frame_start together with din_vld in the same cycle: the pixel belongs to the new frame as (0,0).
- Counter widths: in_y is clog2(ROW+PAD) bits. All comparisons are unsigned, and the centre-row subtraction is performed only when in_y ≥ PAD.

## Timing
- Reset values: all outputs 0, state IDLE.
- lb_din and lb_din_vld are registered, appearing 1 cycle after din/din_vld.
- ctr_x, ctr_y, win_vld and border are delayed LB_LAT cycles after the lb_din_vld that produced them, through a delay pipe.
- FLUSH lasts exactly PAD*COL cycles. frame_done is asserted in the cycle after the last flush shift.
- Reset mid-frame returns immediately to IDLE and empties the delay pipe. Line-buffer contents are not cleared.
- Throughput: one pixel per cycle, and no backpressure on din.

## Structure
- Shared package: state encoding and the CLOG2 function, reused by other pixel-path blocks.
- One sub-module, `vld_delay`: a LB_LAT-deep shift register with asynchronous clear, carrying {win_vld, border, ctr_x, ctr_y}.
- The top instantiates the FSM, the counters and `vld_delay`. `shift_custom` is instantiated by the parent, not inside this block.

## Test plan
- Bench parameters for all scenarios: ROW=6, COL=8, PAD=2, LB_LAT=1.
- Reset, then frame_start and 48 consecutive pixels with value = index → 48 lb_din_vld matching din one cycle later, then 16 zero shifts. frame_done pulses at the cycle after the last flush shift. win_vld is high for exactly 48 cycles.
- Same frame → first win_vld coincides with the tap cycle of input pixel (2,0) and carries ctr=(0,0). The last win_vld carries ctr=(7,5). border is low only for x∈2..5, y∈2..3 (8 centres).
- din_vld toggling 1/0 during RUN → counts advance only on valid cycles. FLUSH still starts only after the 48th pixel.
- din_vld high during FLUSH → err_drop pulses each such cycle, lb_din stays 0, and the flush length stays 16.
- frame_start after 20 pixels → err_abort pulse, counters restart at (0,0) and no frame_done. The next 48 pixels complete normally.
- rst_n low for 1 cycle mid-FLUSH → all outputs 0 and state IDLE. din_vld is then ignored until frame_start.
